knn_vote: RTL

//  Classification stage directly downstream of knn_core. Takes the sorted
//  N-nearest-neighbour list (distance + label per entry) and returns the

---
 rtl/knn_vote_pkg.sv | 16 +
 rtl/knn_vote_hist.sv | 45 ++++
 rtl/knn_vote.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/knn_vote_pkg.sv
// rtl/knn_vote_pkg.sv - shared state encoding for the kNN majority-vote stage
package knn_vote_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_ARGMAX = 2'd2,
    ST_DONE   = 2'd3
  } vote_state_e;

  // An entry votes only if it holds a real distance and an in-range label.
  function automatic logic entry_votes(input logic dist_empty, input logic label_in_range);
    return !dist_empty && label_in_range;
  endfunction

endpackage

// File: rtl/knn_vote_hist.sv
// rtl/knn_vote_hist.sv - per-class vote counters with first-voter index table
module knn_vote_hist #(
  parameter int N_CLASS = 16,
  parameter int CNT_W   = 4,
  parameter int IDX_W   = 4,
  parameter int CLS_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CLS_W-1:0] inc_class,
  input  logic [IDX_W-1:0] inc_idx,
  input  logic [CLS_W-1:0] rd_class,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [IDX_W-1:0] rd_first
);

  logic [CNT_W-1:0] cnt   [N_CLASS];
  logic [IDX_W-1:0] first [N_CLASS];

  // Counters clear on request; first_idx is written only on a class's first vote.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_CLASS; k++) begin
        cnt[k]   <= '0;
        first[k] <= '0;
      end
    end else if (clr) begin
      for (int k = 0; k < N_CLASS; k++) begin
        cnt[k]   <= '0;
        first[k] <= '0;
      end
    end else if (inc) begin
      cnt[inc_class] <= cnt[inc_class] + CNT_W'(1);
      if (cnt[inc_class] == '0) begin
        first[inc_class] <= inc_idx;
      end
    end
  end

  assign rd_cnt   = cnt[rd_class];
  assign rd_first = first[rd_class];

endmodule

// File: rtl/knn_vote.sv
// rtl/knn_vote.sv - majority label of the sorted nearest-neighbour list
module knn_vote
  import knn_vote_pkg::*;
#(
  parameter  int DATA_W      = 32,
  parameter  int LABEL       = 8,
  parameter  int N_NEIGHBOUR = 10,
  parameter  int N_CLASS     = 16,
  localparam int ENTRY_W     = DATA_W + LABEL,
  localparam int CNT_W       = $clog2(N_NEIGHBOUR + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ENTRY_W*N_NEIGHBOUR-1:0] neighbour_info,
  output logic                           busy,
  output logic                           done,
  output logic [LABEL-1:0]               class_label,
  output logic [CNT_W-1:0]               vote_count,
  output logic                           no_vote
);

  localparam int NB_W  = $clog2(N_NEIGHBOUR);
  localparam int CLS_W = $clog2(N_CLASS);

  vote_state_e state, state_nxt;

  logic [DATA_W-1:0] snap_dist  [N_NEIGHBOUR];
  logic [LABEL-1:0]  snap_label [N_NEIGHBOUR];

  logic [NB_W-1:0]  scan_idx;
  logic [CLS_W-1:0] class_idx;
  logic [CNT_W-1:0] best_cnt;
  logic [CLS_W-1:0] best_class;
  logic [NB_W-1:0]  best_idx;

  logic [DATA_W-1:0] cur_dist;
  logic [LABEL-1:0]  cur_label;
  logic              cur_votes;
  logic              scan_last;
  logic              class_last;
  logic              hist_clr;
  logic              hist_inc;
  logic [CNT_W-1:0]  rd_cnt;
  logic [NB_W-1:0]   rd_first;
  logic              better;

  assign cur_dist   = snap_dist[scan_idx];
  assign cur_label  = snap_label[scan_idx];
  assign cur_votes  = entry_votes(cur_dist == {DATA_W{1'b1}}, 32'(cur_label) < N_CLASS);
  assign scan_last  = (scan_idx == NB_W'(N_NEIGHBOUR - 1));
  assign class_last = (class_idx == CLS_W'(N_CLASS - 1));

  // Strictly more votes wins; on a tie the class with the nearer first member wins.
  assign better = (rd_cnt > best_cnt) ||
                  ((rd_cnt == best_cnt) && (best_cnt != '0) && (rd_first < best_idx));

  knn_vote_hist #(
    .N_CLASS (N_CLASS),
    .CNT_W   (CNT_W),
    .IDX_W   (NB_W),
    .CLS_W   (CLS_W)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .clr       (hist_clr),
    .inc       (hist_inc),
    .inc_class (cur_label[CLS_W-1:0]),
    .inc_idx   (scan_idx),
    .rd_class  (class_idx),
    .rd_cnt    (rd_cnt),
    .rd_first  (rd_first)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and histogram control strobes.
  always_comb begin
    state_nxt = state;
    hist_clr  = 1'b0;
    hist_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          hist_clr  = 1'b1;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        hist_inc = cur_votes;
        if (scan_last) begin
          state_nxt = ST_ARGMAX;
        end
      end
      ST_ARGMAX: begin
        if (class_last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Snapshot, index counters, running arg-max and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_NEIGHBOUR; k++) begin
        snap_dist[k]  <= '0;
        snap_label[k] <= '0;
      end
      scan_idx    <= '0;
      class_idx   <= '0;
      best_cnt    <= '0;
      best_class  <= '0;
      best_idx    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      class_label <= '0;
      vote_count  <= '0;
      no_vote     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int k = 0; k < N_NEIGHBOUR; k++) begin
              snap_label[k] <= neighbour_info[k*ENTRY_W +: LABEL];
              snap_dist[k]  <= neighbour_info[k*ENTRY_W + LABEL +: DATA_W];
            end
            scan_idx <= '0;
            busy     <= 1'b1;
          end
        end
        ST_SCAN: begin
          scan_idx <= scan_idx + NB_W'(1);
          if (scan_last) begin
            class_idx  <= '0;
            best_cnt   <= '0;
            best_class <= '0;
            best_idx   <= '1;
          end
        end
        ST_ARGMAX: begin
          class_idx <= class_idx + CLS_W'(1);
          if (better) begin
            best_cnt   <= rd_cnt;
            best_class <= class_idx;
            best_idx   <= rd_first;
          end
        end
        ST_DONE: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          class_label <= LABEL'(best_class);
          vote_count  <= best_cnt;
          no_vote     <= (best_cnt == '0);
        end
        default: ;
      endcase
    end
  end

endmodule
